// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_program_loader
// Description : Loads a framed program image (length, N words, checksum)
//               from a valid/ready host stream into the fetch-stage
//               instruction memory. The core is held in reset until the
//               image is verified, then released from PC reset.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_program_loader #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                MAX_WORDS  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              fm_we,
    output logic [ADDR_W-1:0] fm_addr,
    output logic [DATA_W-1:0] fm_data,
    output logic              fm_rst,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_error
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_CSUM    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_RUN     = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0]        state_q,   state_d;
    logic [DATA_W-1:0] remain_q,  remain_d;   // data words still expected
    logic [ADDR_W-1:0] wptr_q,    wptr_d;     // address of next data word
    logic [DATA_W-1:0] sum_q,     sum_d;      // running modular checksum
    logic              fm_we_q,   fm_we_d;
    logic [ADDR_W-1:0] fm_addr_q, fm_addr_d;
    logic [DATA_W-1:0] fm_data_q, fm_data_d;

    logic w_accept;
    logic w_len_too_big;
    logic w_len_zero;
    logic w_last_word;
    logic w_restart;

    // Handshake completes only when the loader is actually listening.
    assign w_accept = in_valid & in_ready;

    // Length check done in a wide unsigned domain so that any MAX_WORDS
    // (including one above 2^DATA_W-1) compares correctly.
    assign w_len_too_big = (64'(in_data) > 64'(MAX_WORDS));
    assign w_len_zero    = (in_data == '0);
    assign w_last_word   = (remain_q == DATA_W'(1));

    // A new load may only begin from a quiescent state.
    assign w_restart = load_start &&
                       ((state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_ERROR));

    // Next-state and datapath update logic
    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        wptr_d    = wptr_q;
        sum_d     = sum_q;
        fm_we_d   = 1'b0;
        fm_addr_d = fm_addr_q;
        fm_data_d = fm_data_q;

        if (w_restart) begin
            state_d  = S_LEN;
            remain_d = '0;
            wptr_d   = START_ADDR;
            sum_d    = '0;
        end else begin
            case (state_q)
                S_LEN: begin
                    if (w_accept) begin
                        remain_d = in_data;
                        wptr_d   = START_ADDR;
                        sum_d    = '0;
                        if (w_len_too_big) begin
                            state_d = S_ERROR;
                        end else if (w_len_zero) begin
                            state_d = S_CSUM;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (w_accept) begin
                        // Write lands one cycle after the accept; the last
                        // write is therefore visible as CSUM is entered.
                        fm_we_d   = 1'b1;
                        fm_addr_d = wptr_q;
                        fm_data_d = in_data;
                        wptr_d    = wptr_q + ADDR_W'(1);
                        sum_d     = sum_q + in_data;
                        remain_d  = remain_q - DATA_W'(1);
                        if (w_last_word) begin
                            state_d = S_CSUM;
                        end
                    end
                end

                S_CSUM: begin
                    if (w_accept) begin
                        state_d = (in_data == sum_q) ? S_RELEASE : S_ERROR;
                    end
                end

                S_RELEASE: begin
                    // Single cycle with the fetch stage still in reset so
                    // the PC starts cleanly on the new image.
                    state_d = S_RUN;
                end

                S_IDLE, S_RUN, S_ERROR: begin
                    state_d = state_q;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            remain_q  <= '0;
            wptr_q    <= '0;
            sum_q     <= '0;
            fm_we_q   <= 1'b0;
            fm_addr_q <= '0;
            fm_data_q <= '0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            wptr_q    <= wptr_d;
            sum_q     <= sum_d;
            fm_we_q   <= fm_we_d;
            fm_addr_q <= fm_addr_d;
            fm_data_q <= fm_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: status and control decoded directly from state so that an
    // asynchronous reset takes effect on them immediately.
    // ------------------------------------------------------------------------
    assign in_ready   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign fm_rst     = (state_q != S_RUN);
    assign core_hold  = (state_q != S_RUN);
    assign load_done  = (state_q == S_RUN);
    assign load_error = (state_q == S_ERROR);

    assign fm_we      = fm_we_q;
    assign fm_addr    = fm_addr_q;
    assign fm_data    = fm_data_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_program_loader
// Description : Directed self-checking bench for imem_program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_program_loader;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        fm_we;
    logic [31:0] fm_addr;
    logic [15:0] fm_data;
    logic        fm_rst;
    logic        core_hold;
    logic        load_done;
    logic        load_error;

    int checks;
    int failures;
    int we_count;

    imem_program_loader #(
        .DATA_W     (16),
        .ADDR_W     (32),
        .START_ADDR (32'd0),
        .MAX_WORDS  (1024)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .fm_we      (fm_we),
        .fm_addr    (fm_addr),
        .fm_data    (fm_data),
        .fm_rst     (fm_rst),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every memory write seen by the fetch stage.
    always @(negedge clk) begin
        if (fm_we === 1'b1) we_count++;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Status outputs as a 4-bit vector {fm_rst, core_hold, load_done, load_error}
    task automatic chk_status(input string tag, input logic [3:0] exp);
        chk(tag, 32'({fm_rst, core_hold, load_done, load_error}), 32'(exp));
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
        chk("len_in_ready", 32'(in_ready), 32'd1);
        chk_status("len_status", 4'b1100);
    endtask

    // Present one word for a single cycle (loader must be ready), then check
    // the write port; optionally insert one idle bubble afterwards.
    task automatic put(input logic [15:0] w, input bit gap, input bit exp_we,
                       input logic [31:0] exp_addr);
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = w;
        cycle();
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        chk("we_after_accept", 32'(fm_we), 32'(exp_we));
        if (exp_we) begin
            chk("wr_addr", fm_addr, exp_addr);
            chk("wr_data", 32'(fm_data), 32'(w));
        end
        if (gap) begin
            cycle();
            chk("bubble_we", 32'(fm_we), 32'd0);
        end
    endtask

    // Full good image: 3 words 0x1111,0x2222,0x0003; checksum 0x3336.
    task automatic good_image(input bit gap);
        put(16'd3,      gap, 1'b0, 32'd0);
        put(16'h1111,   gap, 1'b1, 32'd0);
        put(16'h2222,   gap, 1'b1, 32'd1);
        put(16'h0003,   1'b0, 1'b1, 32'd2);
        if (gap) begin
            cycle();
            chk("bubble_we_last", 32'(fm_we), 32'd0);
        end
        chk("csum_in_ready", 32'(in_ready), 32'd1);
        put(16'h3336,   1'b0, 1'b0, 32'd0);
        // RELEASE cycle
        chk("release_in_ready", 32'(in_ready), 32'd0);
        chk_status("release_status", 4'b1100);
        cycle();
        chk_status("run_status", 4'b0010);
        chk("run_in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        int wc0;
        checks     = 0;
        failures   = 0;
        we_count   = 0;
        reset      = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 16'h0;

        // ---- 1) reset values ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_fm_we", 32'(fm_we), 32'd0);
        chk("rst_fm_addr", fm_addr, 32'd0);
        chk("rst_fm_data", 32'(fm_data), 32'd0);
        chk_status("rst_status", 4'b1100);
        @(negedge clk);
        reset = 1'b1;
        cycle();
        cycle();
        chk_status("idle_status", 4'b1100);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        // Host word offered while idle must be ignored.
        in_valid = 1'b1;
        in_data  = 16'h0005;
        cycle();
        in_valid = 1'b0;
        chk("idle_no_accept", 32'(in_ready), 32'd0);
        chk("idle_no_we", 32'(fm_we), 32'd0);

        // ---- 2) back-to-back good image ----
        pulse_start();
        good_image(1'b0);

        // ---- 3) same image with bubbles, restarted from RUN ----
        pulse_start();
        good_image(1'b1);

        // ---- 4) bad checksum then recovery ----
        pulse_start();
        put(16'd3,    1'b0, 1'b0, 32'd0);
        put(16'h1111, 1'b0, 1'b1, 32'd0);
        // load_start during DATA must be ignored
        load_start = 1'b1;
        put(16'h2222, 1'b0, 1'b1, 32'd1);
        load_start = 1'b0;
        put(16'h0003, 1'b0, 1'b1, 32'd2);
        put(16'h0000, 1'b0, 1'b0, 32'd0);
        chk_status("badcsum_status", 4'b1101);
        chk("badcsum_in_ready", 32'(in_ready), 32'd0);
        cycle();
        chk_status("error_sticky", 4'b1101);
        pulse_start();
        chk("err_cleared", 32'(load_error), 32'd0);
        good_image(1'b0);

        // ---- 5) length boundaries ----
        wc0 = we_count;
        pulse_start();
        put(16'h0401, 1'b0, 1'b0, 32'd0);
        chk_status("toolong_status", 4'b1101);
        cycle();
        chk("toolong_no_writes", 32'(we_count - wc0), 32'd0);
        pulse_start();
        put(16'h0000, 1'b0, 1'b0, 32'd0);
        chk("zero_len_csum_ready", 32'(in_ready), 32'd1);
        put(16'h0000, 1'b0, 1'b0, 32'd0);
        chk_status("zero_release", 4'b1100);
        cycle();
        chk_status("zero_run", 4'b0010);
        chk("zero_no_writes", 32'(we_count - wc0), 32'd0);

        // ---- 6) asynchronous reset mid-load ----
        pulse_start();
        put(16'd3,    1'b0, 1'b0, 32'd0);
        put(16'h1111, 1'b0, 1'b1, 32'd0);
        put(16'h2222, 1'b0, 1'b1, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_fm_we", 32'(fm_we), 32'd0);
        chk("arst_fm_addr", fm_addr, 32'd0);
        chk("arst_fm_data", 32'(fm_data), 32'd0);
        chk_status("arst_status", 4'b1100);
        @(negedge clk);
        reset = 1'b1;
        cycle();
        chk_status("post_arst_idle", 4'b1100);
        chk("post_arst_ready", 32'(in_ready), 32'd0);
        pulse_start();
        good_image(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
